ovr_i_shutdown: RTL and testbench

OVR_I_SHUTDOWN -- requirements
Module: ovr_i_shutdown

---
 rtl/ovr_i_shutdown_pkg.sv | 5 +
 rtl/sync2.sv | 12 +
 rtl/ovr_i_shutdown.sv | 56 +++++
 tb/tb_ovr_i_shutdown.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ovr_i_shutdown_pkg.sv
// ovr_i_shutdown_pkg: shared motor-drive types and constants
package ovr_i_shutdown_pkg;
  typedef enum logic [1:0] {RUN, TRIPPED, RECOVER} sd_state_t;
  localparam int PWM_PERIOD = 2048;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for asynchronous single-bit inputs
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/ovr_i_shutdown.sv
// ovr_i_shutdown: over-current period counting, trip FSM and trip statistics
module ovr_i_shutdown
  import ovr_i_shutdown_pkg::*;
#(
  parameter int OVR_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       OVR_I,
  input  logic       PWM_synch,
  input  logic       OVR_I_blank_n,
  input  logic       clr_shutdown,
  output logic       shutdown,
  output logic [3:0] ovr_consec,
  output logic [7:0] trip_cnt
);
  sd_state_t state;
  logic ovr_s, flag, hit;
  logic [3:0] nxt;
  sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(OVR_I), .q(ovr_s));
  // hit covers the flag so far plus this cycle, so a synch-cycle event still counts
  assign hit = flag | (ovr_s & OVR_I_blank_n);
  assign nxt = (ovr_consec == 4'd15) ? 4'd15 : ovr_consec + 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= RUN;
      shutdown   <= 1'b0;
      ovr_consec <= 4'd0;
      trip_cnt   <= 8'd0;
      flag       <= 1'b0;
    end else begin
      flag <= (PWM_synch || (state == TRIPPED && clr_shutdown)) ? 1'b0 : hit;
      case (state)
        RUN: if (PWM_synch) begin
          ovr_consec <= hit ? nxt : 4'd0;
          if (hit && nxt == 4'(OVR_LIMIT)) begin
            state    <= TRIPPED;
            shutdown <= 1'b1;
            trip_cnt <= (trip_cnt == 8'hFF) ? trip_cnt : trip_cnt + 8'd1;
          end
        end
        TRIPPED: if (clr_shutdown) begin
          state      <= RECOVER;
          ovr_consec <= 4'd0;
        end
        RECOVER: if (PWM_synch && !hit) begin
          state    <= RUN;
          shutdown <= 1'b0;
        end
        default: begin
          state    <= RUN;
          shutdown <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_ovr_i_shutdown.sv
// tb_ovr_i_shutdown: directed stimulus with a behavioural model checked every cycle
module tb_ovr_i_shutdown;
  localparam int LIM = 4;
  localparam int P = 256;
  logic clk = 1'b0, rst_n = 1'b0, OVR_I = 1'b0, PWM_synch = 1'b0, OVR_I_blank_n = 1'b1, clr_shutdown = 1'b0;
  logic shutdown;
  logic [3:0] ovr_consec;
  logic [7:0] trip_cnt;
  int total = 0, bad = 0, pcnt = 0;
  int m_mode = 0, m_consec = 0, m_trips = 0;
  bit m_flag = 1'b0;
  bit [1:0] m_hist = 2'b00;

  ovr_i_shutdown #(.OVR_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .OVR_I(OVR_I), .PWM_synch(PWM_synch),
    .OVR_I_blank_n(OVR_I_blank_n), .clr_shutdown(clr_shutdown),
    .shutdown(shutdown), .ovr_consec(ovr_consec), .trip_cnt(trip_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model modes: 0 = driving, 1 = tripped, 2 = recovering
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_mode = 0; m_consec = 0; m_trips = 0; m_flag = 1'b0; m_hist = 2'b00;
    end else begin
      bit hit;
      hit = m_flag || (m_hist[1] && OVR_I_blank_n);
      m_flag = (PWM_synch || (m_mode == 1 && clr_shutdown)) ? 1'b0 : hit;
      if (m_mode == 0 && PWM_synch) begin
        m_consec = hit ? ((m_consec < 15) ? m_consec + 1 : 15) : 0;
        if (hit && m_consec == LIM) begin
          m_mode = 1;
          if (m_trips < 255) m_trips++;
        end
      end else if (m_mode == 1 && clr_shutdown) begin
        m_mode = 2;
        m_consec = 0;
      end else if (m_mode == 2 && PWM_synch && !hit)
        m_mode = 0;
      m_hist = {m_hist[0], OVR_I};
    end

  always @(negedge clk) begin
    chk("model_shutdown", int'(shutdown), int'(m_mode != 0));
    chk("model_consec", int'(ovr_consec), m_consec);
    chk("model_trips", int'(trip_cnt), m_trips);
  end

  // modes: 0 quiet, 1 held high, 2 high only inside blanking, 3 lands on synch only, 4 mid-period pulse
  task automatic cyc(input int mode, input bit clr = 1'b0);
    OVR_I = (mode == 1) || (mode == 2 && pcnt < 16) || (mode == 3 && pcnt == P - 3) ||
            (mode == 4 && pcnt >= 10 && pcnt <= 20);
    OVR_I_blank_n = !(mode == 2 && pcnt < 32);
    clr_shutdown = clr;
    @(posedge clk); #1;
    pcnt = (pcnt + 1) % P;
    PWM_synch = (pcnt == P - 1);
  endtask

  task automatic periods(input int n, input int mode);
    repeat (n * P) cyc(mode);
  endtask

  initial begin
    repeat (5) cyc(0);
    chk("rst_shutdown", int'(shutdown), 0);
    chk("rst_consec", int'(ovr_consec), 0);
    chk("rst_trips", int'(trip_cnt), 0);
    rst_n = 1'b1;
    while (pcnt != 0) cyc(0);
    periods(10, 2);
    chk("blank_consec", int'(ovr_consec), 0);
    chk("blank_shutdown", int'(shutdown), 0);
    for (int i = 1; i <= 4; i++) begin
      periods(1, 1);
      chk("held_consec", int'(ovr_consec), i);
      if (i == 3) chk("held_pre_trip", int'(shutdown), 0);
    end
    chk("trip_shutdown", int'(shutdown), 1);
    chk("trip_count1", int'(trip_cnt), 1);
    periods(1, 1);
    chk("tripped_frozen", int'(ovr_consec), 4);
    cyc(4, 1'b1);
    repeat (P - 1) cyc(4);
    chk("recover_dirty_sd", int'(shutdown), 1);
    chk("recover_consec", int'(ovr_consec), 0);
    repeat (P - 1) cyc(0);
    chk("recover_before_synch", int'(shutdown), 1);
    cyc(0);
    chk("recover_release", int'(shutdown), 0);
    periods(3, 4);
    chk("streak_a", int'(ovr_consec), 3);
    periods(1, 0);
    chk("streak_gap", int'(ovr_consec), 0);
    periods(3, 4);
    chk("streak_b", int'(ovr_consec), 3);
    chk("streak_sd", int'(shutdown), 0);
    periods(1, 0);
    periods(1, 3);
    chk("synch_edge_event", int'(ovr_consec), 1);
    cyc(0, 1'b1);
    chk("clr_in_run_sd", int'(shutdown), 0);
    chk("clr_in_run_consec", int'(ovr_consec), 1);
    repeat (P - 1) cyc(0);
    chk("clean_after_edge", int'(ovr_consec), 0);
    periods(4, 4);
    chk("trip_count2", int'(trip_cnt), 2);
    cyc(0, 1'b1);
    repeat (P - 1) cyc(0);
    chk("second_release", int'(shutdown), 0);
    periods(4, 4);
    chk("trip_count3", int'(trip_cnt), 3);
    chk("third_trip_sd", int'(shutdown), 1);
    repeat (50) cyc(4);
    rst_n = 1'b0;
    #2;
    chk("async_rst_sd", int'(shutdown), 0);
    chk("async_rst_trips", int'(trip_cnt), 0);
    chk("async_rst_consec", int'(ovr_consec), 0);
    #1;
    rst_n = 1'b1;
    while (pcnt != 0) cyc(0);
    chk("post_rst_consec", int'(ovr_consec), 0);
    chk("post_rst_sd", int'(shutdown), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
